ram_burst_engine: RTL and testbench

RAM_BURST_ENGINE -- requirements
Module: ram_burst_engine

---
 rtl/ram_burst_engine.sv | 143 ++++++++++++++
 tb/tb_ram_burst_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_engine.sv
// Cache-line burst engine: splits one line request into critical-word-first
// RAM beats with per-beat ack timeout.
module ram_burst_engine #(
  parameter int ADDR_SIZE  = 13,
  parameter int LINE_WIDTH = 64,
  parameter int WORD_SIZE  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  not_reset,
  input  logic                  cache_avalid,
  input  logic                  cache_rnw,
  input  logic [ADDR_SIZE-1:0]  cache_addr,
  input  logic [LINE_WIDTH-1:0] cache_wdata,
  output logic [LINE_WIDTH-1:0] cache_rdata,
  output logic                  cache_ack,
  output logic                  cache_err,
  output logic                  busy,
  output logic [ADDR_SIZE-1:0]  ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  output logic                  ram_rnw,
  output logic                  ram_avalid,
  input  logic [WORD_SIZE-1:0]  ram_rdata,
  input  logic                  ram_ack
);

  localparam int BEATS = LINE_WIDTH / WORD_SIZE;
  localparam int B     = $clog2(BEATS);
  localparam int WW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);

  localparam logic [B-1:0]  LAST_BEAT = B'(BEATS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [B-1:0]             r_beat;
  logic [WW-1:0]            r_wait;
  logic [B-1:0]             r_k0;
  logic [ADDR_SIZE-B-1:0]   r_hi;
  logic                     r_rnw;
  logic [LINE_WIDTH-1:0]    r_line;
  logic [LINE_WIDTH-1:0]    r_rdata;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_busy;
  logic [ADDR_SIZE-1:0]     r_addr;
  logic [WORD_SIZE-1:0]     r_wdata;
  logic                     r_avalid;

  logic [B-1:0] w_k;
  logic [B-1:0] w_k_nxt;
  logic         w_timeout;

  assign w_k       = r_k0 + r_beat;
  assign w_k_nxt   = w_k + 1'b1;
  assign w_timeout = TO_EN && (r_wait == LAST_WAIT);

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_wait   <= '0;
      r_k0     <= '0;
      r_hi     <= '0;
      r_rnw    <= 1'b0;
      r_line   <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_avalid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cache_avalid) begin
            r_state  <= S_XFER;
            r_rnw    <= cache_rnw;
            r_line   <= cache_wdata;
            r_hi     <= cache_addr[ADDR_SIZE-1:B];
            r_k0     <= cache_addr[B-1:0];
            r_beat   <= '0;
            r_wait   <= '0;
            r_busy   <= 1'b1;
            r_avalid <= 1'b1;
            r_addr   <= cache_addr;
            r_wdata  <= cache_wdata[32'(cache_addr[B-1:0])*WORD_SIZE +: WORD_SIZE];
          end
        end
        S_XFER: begin
          if (ram_ack) begin
            if (r_rnw)
              r_rdata[32'(w_k)*WORD_SIZE +: WORD_SIZE] <= ram_rdata;
            r_wait <= '0;
            if (r_beat == LAST_BEAT) begin
              r_state  <= S_DONE;
              r_avalid <= 1'b0;
              r_ack    <= 1'b1;
              r_err    <= 1'b0;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_addr  <= {r_hi, w_k_nxt};
              r_wdata <= r_line[32'(w_k_nxt)*WORD_SIZE +: WORD_SIZE];
            end
          end else if (w_timeout) begin
            // abandon the line; words already landed stay in r_rdata
            r_state  <= S_DONE;
            r_avalid <= 1'b0;
            r_ack    <= 1'b1;
            r_err    <= 1'b1;
            r_wait   <= '0;
          end else if (TO_EN) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cache_rdata = r_rdata;
  assign cache_ack   = r_ack;
  assign cache_err   = r_err;
  assign busy        = r_busy;
  assign ram_addr    = r_addr;
  assign ram_wdata   = r_wdata;
  assign ram_rnw     = r_rnw;
  assign ram_avalid  = r_avalid;

endmodule

// File: tb/tb_ram_burst_engine.sv
// Bench for ram_burst_engine: directed table, corner sequences and
// random bursts against a word-level RAM/line model.
module tb_ram_burst_engine;

  localparam int AW = 13;
  localparam int LW = 64;
  localparam int WS = 16;
  localparam int TO = 4;
  localparam int NB = LW / WS;

  logic          clk = 1'b0;
  logic          not_reset = 1'b0;
  logic          cache_avalid = 1'b0;
  logic          cache_rnw = 1'b0;
  logic [AW-1:0] cache_addr = '0;
  logic [LW-1:0] cache_wdata = '0;
  logic [LW-1:0] cache_rdata;
  logic          cache_ack;
  logic          cache_err;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [WS-1:0] ram_wdata;
  logic          ram_rnw;
  logic          ram_avalid;
  logic [WS-1:0] ram_rdata = '0;
  logic          ram_ack = 1'b0;

  always #5 clk = ~clk;

  ram_burst_engine #(
    .ADDR_SIZE (AW),
    .LINE_WIDTH(LW),
    .WORD_SIZE (WS),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .not_reset   (not_reset),
    .cache_avalid(cache_avalid),
    .cache_rnw   (cache_rnw),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_rdata (cache_rdata),
    .cache_ack   (cache_ack),
    .cache_err   (cache_err),
    .busy        (busy),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rnw     (ram_rnw),
    .ram_avalid  (ram_avalid),
    .ram_rdata   (ram_rdata),
    .ram_ack     (ram_ack)
  );

  int g_vec = 0;
  int g_err = 0;

  logic [WS-1:0] mem [0:(1<<AW)-1];
  logic [WS-1:0] m_word [NB];
  int            dly [NB];
  int            dut_av;
  bit            aborted;
  logic          last_err;

  typedef struct {
    bit            rnw;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
    int            d0, d1, d2, d3;
    logic [LW-1:0] exp_rdata;
    bit            exp_err;
    int            exp_cyc;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [LW-1:0] m_line();
    return {m_word[3], m_word[2], m_word[1], m_word[0]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    g_vec++;
    if (act !== exp) begin
      g_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge of
  // the idle cycle that follows DONE.
  task automatic run_xfer(input bit rnw, input logic [AW-1:0] a,
                          input logic [LW-1:0] wd, input bit hold,
                          input logic [AW-1:0] a_after);
    int k;
    int w;
    bit acked;
    logic [AW-1:0] ea;
    cache_avalid = 1'b1;
    cache_rnw    = rnw;
    cache_addr   = a;
    cache_wdata  = wd;
    @(posedge clk);
    #1;
    if (!hold) begin
      cache_avalid = 1'b0;
      cache_rnw    = ~rnw;
    end
    cache_addr  = a_after;
    cache_wdata = ~wd;
    aborted = 1'b0;
    dut_av  = 0;
    for (int i = 0; i < NB && !aborted; i++) begin
      k  = (int'(a) + i) % NB;
      ea = AW'((int'(a) / NB) * NB + k);
      w  = 0;
      acked = 1'b0;
      while (!acked && !aborted) begin
        @(negedge clk);
        if (ram_avalid) dut_av++;
        chk("xfer_ctl", {ram_avalid, busy, cache_ack, cache_err, ram_rnw, ram_addr},
            {1'b1, 1'b1, 1'b0, 1'b0, rnw, ea});
        if (!rnw) chk("xfer_wdata", ram_wdata, wd[k*WS +: WS]);
        if (w == dly[i]) begin
          ram_ack   = 1'b1;
          ram_rdata = mem[ea];
          acked     = 1'b1;
          if (rnw) m_word[k] = mem[ea];
          else     mem[ea]   = wd[k*WS +: WS];
        end else begin
          ram_ack   = 1'b0;
          ram_rdata = WS'($urandom);
          if (w == TO - 1) aborted = 1'b1;
          w++;
        end
      end
    end
    @(negedge clk);
    last_err = cache_err;
    chk("done_ctl", {ram_avalid, busy, cache_ack, cache_err},
        {1'b0, 1'b1, 1'b1, aborted});
    chk("done_rdata", cache_rdata, m_line());
    ram_ack   = 1'($urandom);
    ram_rdata = WS'($urandom);
    @(negedge clk);
    chk("idle_ctl", {ram_avalid, busy, cache_ack, cache_err}, 4'b0);
    ram_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, g_err=%0d", g_err);
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] snap;
    for (int a = 0; a < (1 << AW); a++)
      mem[a] = (a < 16) ? WS'(16'h1111 * (a % 4)) : WS'(a ^ 16'hA5A5);
    for (int i = 0; i < NB; i++) m_word[i] = '0;

    tbl[0] = '{1'b1, 13'h005, 64'h0, 0, 0, 0, 0,
               64'h3333_2222_1111_0000, 1'b0, 4};
    tbl[1] = '{1'b0, 13'h010, 64'hDDDD_CCCC_BBBB_AAAA, 3, 3, 3, 3,
               64'h3333_2222_1111_0000, 1'b0, 16};
    tbl[2] = '{1'b1, 13'h0A2, 64'h0, 0, 0, 9, 0,
               64'hA506_A507_1111_0000, 1'b1, 6};
    tbl[3] = '{1'b0, 13'h1FFF, 64'h0123_4567_89AB_CDEF, 5, 0, 0, 0,
               64'hA506_A507_1111_0000, 1'b1, 4};
    tbl[4] = '{1'b1, 13'h008, 64'h0, 2, 0, 1, 0,
               64'h3333_2222_1111_0000, 1'b0, 7};

    repeat (3) @(negedge clk);
    chk("reset_outs", {cache_rdata, cache_ack, cache_err, busy, ram_avalid,
                       ram_rnw, ram_addr, ram_wdata}, '0);
    not_reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      dly = '{tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3};
      run_xfer(tbl[v].rnw, tbl[v].addr, tbl[v].wd, 1'b0, 13'h1ABC);
      chk("tbl_rdata", cache_rdata, tbl[v].exp_rdata);
      chk("tbl_err", last_err, tbl[v].exp_err);
      chk("tbl_avalid_cycles", dut_av, tbl[v].exp_cyc);
    end

    // stray acks while idle
    snap = m_line();
    for (int c = 0; c < 3; c++) begin
      ram_ack   = 1'b1;
      ram_rdata = WS'($urandom);
      @(negedge clk);
      chk("stray_ack", {cache_rdata, ram_avalid, busy, cache_ack, cache_err},
          {snap, 4'b0});
    end
    ram_ack = 1'b0;

    // request held high, address changed mid-burst
    dly = '{0, 0, 0, 0};
    run_xfer(1'b1, 13'h004, 64'h0, 1'b1, 13'h00C);
    run_xfer(1'b1, 13'h00C, 64'h0, 1'b0, 13'h0000);
    chk("hold_second_line", cache_rdata, 64'h3333_2222_1111_0000);

    // reset during beat 2 of a read
    cache_avalid = 1'b1;
    cache_rnw    = 1'b1;
    cache_addr   = 13'h008;
    @(posedge clk);
    #1;
    cache_avalid = 1'b0;
    ram_ack      = 1'b1;
    ram_rdata    = 16'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_beat2_addr", ram_addr, 13'h00A);
    not_reset = 1'b0;
    #1;
    for (int i = 0; i < NB; i++) m_word[i] = '0;
    chk("rst_async_outs", {cache_rdata, cache_ack, cache_err, busy, ram_avalid,
                           ram_rnw, ram_addr, ram_wdata}, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_ack", {cache_ack, busy, ram_avalid}, 3'b0);
    end
    ram_ack   = 1'b0;
    not_reset = 1'b1;
    @(negedge clk);
    dly = '{0, 0, 0, 0};
    run_xfer(1'b1, 13'h008, 64'h0, 1'b0, 13'h0777);
    chk("post_rst_line", cache_rdata, 64'h3333_2222_1111_0000);

    // random bursts with random wait states and occasional timeouts
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NB; i++) dly[i] = $urandom_range(0, 5);
      run_xfer(1'($urandom), AW'($urandom), {$urandom, $urandom},
               1'b0, AW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", g_vec, g_err);
    $finish;
  end

endmodule
